panel_scan: RTL

HUB75 scan driver: the consumer side of the pixel-request handshake. It walks every column of each scan row and requests the top-half and bottom-half pixel from the pixel generator. It accepts each response with an ack, thresholds the colour, shifts the bits into the panel, and latches and displays the row. At the end of each frame it optionally sends an animation tick back to the generator.

---
 rtl/panel_scan_if.sv | 24 ++
 rtl/panel_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/panel_scan_if.sv
// Pixel request/response bus between the HUB75 scan driver and the pixel generator.
// master = scan driver (issues requests, acks responses), slave = generator.
interface panel_scan_if;
  logic       pix_valid;
  logic       pix_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_ready;
  logic       pix_valid_in;
  logic [7:0] pix_red;
  logic [7:0] pix_green;
  logic [7:0] pix_blue;
  logic       pix_ack;

  modport master (
    output pix_valid, pix_tick, pix_x, pix_y, pix_ack,
    input  pix_ready, pix_valid_in, pix_red, pix_green, pix_blue
  );

  modport slave (
    input  pix_valid, pix_tick, pix_x, pix_y, pix_ack,
    output pix_ready, pix_valid_in, pix_red, pix_green, pix_blue
  );
endinterface

// File: rtl/panel_scan.sv
// HUB75 scan driver: requests top/bottom pixels per column, shifts MSB colour bits, latches and displays each row.
// Optional PANEL_TICK_EN adds a pix_valid+pix_tick pulse after the last row of every frame.
module panel_scan #(
  parameter int WIDTH          = 32,
  parameter int ROWS           = 16,
  parameter int DISPLAY_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  panel_scan_if.master pix,
  output logic         r0,
  output logic         g0,
  output logic         b0,
  output logic         r1,
  output logic         g1,
  output logic         b1,
  output logic [3:0]   addr,
  output logic         sclk,
  output logic         latch,
  output logic         oe_n
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    ROW_LAST = 4'(ROWS / 2 - 1);
  localparam logic [15:0]   CNT_LAST = 16'(DISPLAY_CYCLES - 1);
  localparam logic [9:0]    BOT_OFS  = 10'(ROWS / 2);

  localparam logic [3:0] S_FLUSH    = 4'd0;
  localparam logic [3:0] S_REQ_TOP  = 4'd1;
  localparam logic [3:0] S_WAIT_TOP = 4'd2;
  localparam logic [3:0] S_REQ_BOT  = 4'd3;
  localparam logic [3:0] S_WAIT_BOT = 4'd4;
  localparam logic [3:0] S_SETUP    = 4'd5;
  localparam logic [3:0] S_CLK      = 4'd6;
  localparam logic [3:0] S_BLANK    = 4'd7;
  localparam logic [3:0] S_LATCH    = 4'd8;
  localparam logic [3:0] S_DISPLAY  = 4'd9;
`ifdef PANEL_TICK_EN
  localparam logic [3:0] S_TICK     = 4'd10;
`endif

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    top_q, top_d;
  logic [5:0]    pan_q, pan_d;
  logic [3:0]    addr_q, addr_d;
  logic          sclk_q, latch_q, oe_n_q;
  logic [9:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [9:0]    cur_x, cur_y;
  logic          last_vld_q;
  logic          fire_req, fire_tick, ack;
  logic [2:0]    rsp_msb;

  assign rsp_msb = {pix.pix_red[7], pix.pix_green[7], pix.pix_blue[7]};

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    pan_d     = pan_q;
    fire_req  = 1'b0;
    fire_tick = 1'b0;
    ack       = 1'b0;
    cur_x     = 10'(col_q);
    cur_y     = (state_q == S_REQ_BOT) ? ({6'd0, row_q} + BOT_OFS) : {6'd0, row_q};
    case (state_q)
      S_FLUSH: begin
        if (pix.pix_valid_in) ack = 1'b1;
        else                  state_d = S_REQ_TOP;
      end
      // A request right after the tick pulse waits one cycle so pix_valid never stays high twice in a row.
      S_REQ_TOP, S_REQ_BOT: begin
        if (pix.pix_ready && !last_vld_q) begin
          fire_req = 1'b1;
          state_d  = (state_q == S_REQ_TOP) ? S_WAIT_TOP : S_WAIT_BOT;
        end
      end
      S_WAIT_TOP: begin
        if (pix.pix_valid_in) begin
          ack     = 1'b1;
          top_d   = rsp_msb;
          state_d = S_REQ_BOT;
        end
      end
      S_WAIT_BOT: begin
        if (pix.pix_valid_in) begin
          ack     = 1'b1;
          pan_d   = {top_q, rsp_msb};
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_CLK;
      S_CLK: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = S_BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_REQ_TOP;
        end
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: state_d = S_DISPLAY;
      S_DISPLAY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
`ifdef PANEL_TICK_EN
            state_d = S_TICK;
`else
            state_d = S_REQ_TOP;
`endif
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ_TOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PANEL_TICK_EN
      S_TICK: begin
        fire_tick = 1'b1;
        state_d   = S_REQ_TOP;
      end
`endif
      default: state_d = S_FLUSH;
    endcase
    pix_x_d = fire_req ? cur_x : pix_x_q;
    pix_y_d = fire_req ? cur_y : pix_y_q;
    addr_d  = (state_d == S_BLANK) ? row_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FLUSH;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      top_q      <= '0;
      pan_q      <= '0;
      addr_q     <= '0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      top_q      <= top_d;
      pan_q      <= pan_d;
      addr_q     <= addr_d;
      sclk_q     <= (state_d == S_CLK);
      latch_q    <= (state_d == S_LATCH);
      oe_n_q     <= (state_d != S_DISPLAY);
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      last_vld_q <= fire_req | fire_tick;
    end
  end

  // Strobes are decoded in the current cycle; reset masks them so a pending response is left for FLUSH.
  assign pix.pix_valid = (fire_req | fire_tick) & ~reset;
  assign pix.pix_ack   = ack & ~reset;
`ifdef PANEL_TICK_EN
  assign pix.pix_tick  = fire_tick & ~reset;
`else
  assign pix.pix_tick  = 1'b0;
`endif
  assign pix.pix_x     = (fire_req && !reset) ? cur_x : pix_x_q;
  assign pix.pix_y     = (fire_req && !reset) ? cur_y : pix_y_q;

  assign {r0, g0, b0, r1, g1, b1} = pan_q;
  assign addr  = addr_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;
  assign oe_n  = oe_n_q;

  logic unused_colour_lsbs;
  assign unused_colour_lsbs = ^{pix.pix_red[6:0], pix.pix_green[6:0], pix.pix_blue[6:0]};

endmodule
